// File: rtl/npc_pkg.sv
// npc_pkg: shared constants and IFU state encoding for the NPC core
package npc_pkg;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    typedef logic [2:0] ifu_state_t;
    localparam ifu_state_t S_IDLE = 3'd0;
    localparam ifu_state_t S_REQ  = 3'd1;
    localparam ifu_state_t S_WAIT = 3'd2;
    localparam ifu_state_t S_OUT  = 3'd3;
    localparam ifu_state_t S_HALT = 3'd4;
endpackage

// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch with redirect, halt and delivery count
module ifu #(
    parameter logic [31:0] RESET_PC = npc_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] fetch_cnt
);
    import npc_pkg::*;
    ifu_state_t  state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        discard;
    logic        halt_q;
    logic        stop;
    assign stop           = halt | halt_q;
    assign imem_req_valid = state == S_REQ;
    assign imem_addr      = pc;
    assign inst_valid     = state == S_OUT;
    // fetch sequencing: request, wait for response, hold for decode, then advance or stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            pend_pc    <= RESET_PC;
            discard    <= 1'b0;
            halt_q     <= 1'b0;
            inst       <= NOP;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            if (halt)
                halt_q <= 1'b1;
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (stop)
                        state <= S_HALT;
                    else begin
                        if (redirect_valid) begin
                            pend_pc <= redirect_pc;
                            discard <= 1'b1;
                        end
                        if (imem_req_ready)
                            state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pend_pc <= redirect_pc;
                        discard <= 1'b1;
                    end
                    if (imem_rsp_valid) begin
                        discard <= 1'b0;
                        if (stop)
                            state <= S_HALT;
                        else if (discard || redirect_valid) begin
                            pc    <= redirect_valid ? redirect_pc : pend_pc;
                            state <= S_REQ;
                        end else begin
                            inst       <= imem_rsp_data;
                            inst_fault <= imem_rsp_err;
                            inst_pc    <= pc;
                            state      <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        fetch_cnt <= fetch_cnt + 32'd1;
                        pc        <= redirect_valid ? redirect_pc : pc + 32'd4;
                        state     <= (inst_fault || stop) ? S_HALT : S_REQ;
                    end else if (redirect_valid && !stop) begin
                        pc    <= redirect_pc;
                        state <= S_REQ;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized scoreboard bench for the instruction fetch unit
module tb_ifu;
    import npc_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;
    logic        inst_fault;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [31:0] fetch_cnt;

    ifu dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_fault(inst_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] cur_pc;
    logic [31:0] delivered;
    logic        halted = 1'b0;
    int          rdy_pct = 100, mem_pct = 100, lat_max = 0, redir_pct = 0;
    logic        hold_ready = 1'b0;
    logic        dr_wait = 1'b0, dr_hs = 1'b0;
    logic [31:0] dr_target = '0, dr_hs_pc = '0;
    logic        busy = 1'b0;
    int          lat = 0;
    logic [31:0] raddr = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a == err_addr);
    endfunction

    function automatic exp_t mk(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.data = mem_data(a);
        e.err  = mem_err(a);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // memory model, IDU and EXU stimulus, and the reference model of the delivered stream
    always @(negedge clk) begin
        logic ctx, hs;
        if (rst_n) begin
            ctx = imem_req_valid || inst_valid || busy;
            imem_rsp_valid = 1'b0;
            if (busy) begin
                if (lat == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_data(raddr);
                    imem_rsp_err   = mem_err(raddr);
                    busy = 1'b0;
                end else
                    lat--;
            end
            imem_req_ready = $urandom_range(99) < mem_pct;
            inst_ready     = !hold_ready && ($urandom_range(99) < rdy_pct);
            redirect_valid = 1'b0;
            if (!halted && ctx && $urandom_range(99) < redir_pct) begin
                redirect_valid = 1'b1;
                redirect_pc    = RESET_PC + ($urandom_range(0, 63) << 2);
            end
            if (dr_wait && ctx && !imem_req_valid && !inst_valid) begin
                redirect_valid = 1'b1;
                redirect_pc    = dr_target;
                dr_wait        = 1'b0;
            end
            if (dr_hs && inst_valid && inst_pc == dr_hs_pc) begin
                inst_ready     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = dr_target;
                dr_hs          = 1'b0;
            end
            hs = inst_valid && inst_ready;
            if (imem_req_valid && imem_req_ready) begin
                busy  = 1'b1;
                raddr = imem_addr;
                lat   = $urandom_range(0, lat_max);
            end
            if (hs) begin
                if (mem_err(cur_pc))
                    halted = 1'b1;
                else begin
                    cur_pc = redirect_valid ? redirect_pc : cur_pc + 32'd4;
                    exp_q.push_back(mk(cur_pc));
                end
            end else if (redirect_valid) begin
                cur_pc = redirect_pc;
                if (exp_q.size() > 0)
                    void'(exp_q.pop_back());
                exp_q.push_back(mk(cur_pc));
            end
        end
    end

    // monitor: every delivered instruction is checked against the head of the expectation queue
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc %h expected none", inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst", inst, e.data);
                check("inst_fault", {31'd0, inst_fault}, {31'd0, e.err});
                check("fetch_cnt", fetch_cnt, delivered);
            end
            delivered = delivered + 32'd1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        halt = 1'b0;
        halted = 1'b0;
        busy = 1'b0;
        dr_wait = 1'b0;
        dr_hs = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        imem_req_ready = 1'b0;
        exp_q.delete();
        delivered = '0;
        cur_pc = RESET_PC;
        exp_q.push_back(mk(RESET_PC));
        repeat (2) @(posedge clk);
        #2;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_fault", {31'd0, inst_fault}, 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        check("rst_addr", imem_addr, 32'h8000_0000);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check(name, {30'd0, imem_req_valid, inst_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] h_inst, h_pc, h_cnt;
        int k;
        do_reset();
        repeat (12) @(posedge clk);
        #2;
        check("cnt_after_12", fetch_cnt, 32'd3);

        hold_ready = 1'b1;
        for (k = 0; k < 20 && !inst_valid; k++) step();
        check("hold_reach_out", {31'd0, inst_valid}, 32'd1);
        h_inst = inst;
        h_pc = inst_pc;
        h_cnt = fetch_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_inst", inst, h_inst);
            check("hold_pc", inst_pc, h_pc);
            check("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
            check("hold_cnt", fetch_cnt, h_cnt);
        end
        hold_ready = 1'b0;

        dr_hs_pc = 32'h8000_0010;
        dr_target = 32'h8000_0200;
        dr_hs = 1'b1;
        for (k = 0; k < 30 && dr_hs; k++) step();
        check("hs_redirect_fired", {31'd0, dr_hs}, 32'd0);
        for (k = 0; k < 10 && !imem_req_valid; k++) step();
        check("hs_redirect_addr", imem_addr, 32'h8000_0200);

        dr_target = 32'h8000_0100;
        dr_wait = 1'b1;
        for (k = 0; k < 30 && dr_wait; k++) step();
        check("wait_redirect_fired", {31'd0, dr_wait}, 32'd0);
        for (k = 0; k < 10 && !imem_req_valid; k++) step();
        check("wait_redirect_addr", imem_addr, 32'h8000_0100);

        rdy_pct = 70;
        mem_pct = 60;
        lat_max = 3;
        redir_pct = 8;
        repeat (3000) @(posedge clk);
        rdy_pct = 100;
        mem_pct = 100;
        lat_max = 0;
        redir_pct = 0;
        #2;

        err_addr = 32'h8000_0008;
        do_reset();
        for (k = 0; k < 100 && !halted; k++) step();
        check("err_halted", {31'd0, halted}, 32'd1);
        expect_quiet("err_quiet", 10);
        check("err_cnt", fetch_cnt, 32'd3);
        err_addr = 32'hFFFF_FFFF;

        mem_pct = 0;
        do_reset();
        for (k = 0; k < 10 && !imem_req_valid; k++) step();
        check("halt_in_req", {31'd0, imem_req_valid}, 32'd1);
        halt = 1'b1;
        halted = 1'b1;
        exp_q.delete();
        expect_quiet("halt_quiet", 10);
        mem_pct = 100;
        do_reset();
        for (k = 0; k < 10 && !imem_req_valid; k++) step();
        check("restart_addr", imem_addr, 32'h8000_0000);
        for (k = 0; k < 20 && fetch_cnt == 0; k++) step();
        check("restart_cnt", fetch_cnt, 32'd1);

        dr_hs_pc = 32'h8000_0004;
        dr_target = 32'h8000_0102;
        dr_hs = 1'b1;
        for (k = 0; k < 100 && !halted; k++) step();
        check("misalign_halted", {31'd0, halted}, 32'd1);
        expect_quiet("misalign_quiet", 5);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
